fwd_operand_stage: RTL

Parametrised successor to the 3-input forwarding mux. It sits between the ID stage and the EX stage of the pipelined CPU. It resolves EX/MEM and MEM/WB forwarding for both source operands and detects load-use hazards, inserting a one-cycle bubble when one occurs. It registers the selected operands into the ID/EX boundary and supports downstream stall and flush.

---
 rtl/fwd_operand_stage.sv | 114 +++++++++++
 1 files changed

// File: rtl/fwd_operand_stage.sv
// ID/EX operand stage: EX/MEM and MEM/WB forwarding per operand, load-use bubble insertion.
// Latency: one cycle from ID inputs to registered outputs; id_stall_o is combinational.
// Backpressure: stall_i freezes the slot, flush_i squashes it; flush outranks stall, stall outranks the bubble.
module fwd_operand_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [ADDR_W-1:0] id_rs_i,
    input  logic [ADDR_W-1:0] id_rt_i,
    input  logic              id_use_rs_i,
    input  logic              id_use_rt_i,
    input  logic [DATA_W-1:0] id_rs_data_i,
    input  logic [DATA_W-1:0] id_rt_data_i,
    input  logic              ex_regwrite_i,
    input  logic              ex_memread_i,
    input  logic [ADDR_W-1:0] ex_rd_i,
    input  logic [DATA_W-1:0] ex_result_i,
    input  logic              mem_regwrite_i,
    input  logic [ADDR_W-1:0] mem_rd_i,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic              id_stall_o,
    output logic              valid_o,
    output logic [DATA_W-1:0] op_a_o,
    output logic [DATA_W-1:0] op_b_o,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o
);

    logic              w_ex_wr_nz;
    logic              w_mem_wr_nz;
    logic              w_ex_a;
    logic              w_ex_b;
    logic              w_mem_a;
    logic              w_mem_b;
    logic [1:0]        w_sel_a;
    logic [1:0]        w_sel_b;
    logic [DATA_W-1:0] w_op_a;
    logic [DATA_W-1:0] w_op_b;
    logic              w_hazard;

    logic              r_valid;
    logic [DATA_W-1:0] r_op_a;
    logic [DATA_W-1:0] r_op_b;
    logic [1:0]        r_fwd_a;
    logic [1:0]        r_fwd_b;

    // Register 0 is hardwired zero, so a write to it is never a forwarding source.
    assign w_ex_wr_nz  = ex_regwrite_i  && (ex_rd_i  != '0);
    assign w_mem_wr_nz = mem_regwrite_i && (mem_rd_i != '0);

    assign w_ex_a  = w_ex_wr_nz  && (ex_rd_i  == id_rs_i);
    assign w_ex_b  = w_ex_wr_nz  && (ex_rd_i  == id_rt_i);
    assign w_mem_a = w_mem_wr_nz && (mem_rd_i == id_rs_i);
    assign w_mem_b = w_mem_wr_nz && (mem_rd_i == id_rt_i);

    // Youngest producer wins: EX/MEM is checked before MEM/WB.
    assign w_sel_a = w_ex_a ? 2'b10 : (w_mem_a ? 2'b01 : 2'b00);
    assign w_sel_b = w_ex_b ? 2'b10 : (w_mem_b ? 2'b01 : 2'b00);

    always_comb begin
        w_op_a = id_rs_data_i;
        w_op_b = id_rt_data_i;
        case (w_sel_a)
            2'b10:   w_op_a = ex_result_i;
            2'b01:   w_op_a = mem_data_i;
            default: w_op_a = id_rs_data_i;
        endcase
        case (w_sel_b)
            2'b10:   w_op_b = ex_result_i;
            2'b01:   w_op_b = mem_data_i;
            default: w_op_b = id_rt_data_i;
        endcase
    end

    // A load's data is not ready in EX/MEM; only operands actually read can stall.
    assign w_hazard = id_valid_i && ex_memread_i && w_ex_wr_nz &&
                      ((id_use_rs_i && w_ex_a) || (id_use_rt_i && w_ex_b));

    assign id_stall_o = w_hazard && !flush_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_valid <= 1'b0;
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_fwd_a <= 2'b00;
            r_fwd_b <= 2'b00;
        end else if (flush_i || (!stall_i && w_hazard)) begin
            r_valid <= 1'b0;
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_fwd_a <= 2'b00;
            r_fwd_b <= 2'b00;
        end else if (!stall_i) begin
            r_valid <= id_valid_i;
            r_op_a  <= w_op_a;
            r_op_b  <= w_op_b;
            r_fwd_a <= w_sel_a;
            r_fwd_b <= w_sel_b;
        end
    end

    assign valid_o = r_valid;
    assign op_a_o  = r_op_a;
    assign op_b_o  = r_op_b;
    assign fwd_a_o = r_fwd_a;
    assign fwd_b_o = r_fwd_b;

endmodule
